alu_issue_unit: RTL and testbench
=================================

# alu_issue_unit

Two-stage issue front-end that feeds the shared ALU. It accepts an instruction word plus register operands over a valid/ready handshake and decodes OP, OP-IMM and BRANCH into the 5-bit ALUOp encoding. It drives the ALU's A/B/ALUOp inputs from a registered decode stage, then captures Result/Flag into an output register presented on a second valid/ready handshake. The unit sits between the register-read logic and writeback/branch-resolve; the ALU itself is instantiated beside it, not inside it.

## Interface
- N, 32, datapath width
- logN, 5, shift-amount width (log2 N)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream offers Instr/Rs1Val/Rs2Val
- in_ready  out  1  unit accepts this cycle
- Instr  in  32  RV32 instruction word
- Rs1Val, Rs2Val  in  N  register operands
- A, B  out  N  to ALU operands
- ALUOp  out  5  to ALU operation select
- Result  in  N  from ALU
- Flag  in  1  from ALU
- out_valid  out  1  output register holds an entry
- out_ready  in  1  downstream consumes this cycle
- OutResult  out  N  ALU result (0 for branch/illegal)
- OutTaken  out  1  branch condition true
- OutIllegal  out  1  instruction not decodable
- OutRd  out  5  Instr[11:7] for OP/OP-IMM, else 0

## Operation
- ALUOp codes: ADD 00000, SUB 01000, SLL 00001, SLT 11100, SLTU 11110, XOR 00100, SRL 00101, SRA 01101, OR 00110, AND 00111, EQ 11000, NE 11001, LT 11100, GE 11101, LTU 11110, GEU 11111.
- OP (0110011): A=Rs1Val, B=Rs2Val; funct3/funct7[5] select op; funct7 other than 0000000/0100000, or 0100000 with funct3 not 000/101 -> illegal.
- OP-IMM (0010011): B = sign-extended Instr[31:20]; shifts use B = zero-extended Instr[24:20]; SRAI when funct7=0100000; SLLI/SRLI with nonzero funct7 (other than SRAI) -> illegal; no SUBI.
- BRANCH (1100011): funct3 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 illegal.
- Any other opcode -> illegal.
- Taken source: for ALUOp 11100/11110 OutTaken = Result[0]; for other branch codes OutTaken = Flag. Non-branch: OutTaken=0.
- Illegal entry: stage 1 drives ALUOp=00000, A=B=0; output OutResult=0, OutTaken=0, OutRd=0, OutIllegal=1. Illegal entries still flow and handshake normally.
- Stage 1 (decode reg): s1_valid, ALUOp, A, B, kind (OP/BR/ILL), rd. A/B/ALUOp ports are driven directly from these registers.
- Stage 2 (output reg): captures Result/Flag-derived fields when stage 1 advances.
- Advance rules: s2_free = !out_valid || out_ready; s1 moves to s2 when s1_valid && s2_free; in_ready = !s1_valid || s2_free (combinational, no skid buffer).

## Timing
- Reset: s1_valid=0, out_valid=0, A=B=0, ALUOp=00000, OutResult=0, OutTaken=0, OutIllegal=0, OutRd=0; in_ready=1 the cycle after reset.
- Latency: accept at edge k -> out_valid at edge k+1 with no backpressure (data visible 2 cycles after presentation).
- Throughput: 1 per cycle while out_ready=1.
- Backpressure: out_ready=0 with both stages full -> in_ready=0; stage-1 registers and A/B/ALUOp hold stable.
- Simultaneous: out_ready=1 and in_valid=1 with both stages full -> output pops, s1->s2, new entry enters s1 on the same edge.
- Output fields are stable while out_valid=1 && out_ready=0.
- rst mid-stream discards both stages; no output handshake completes on the reset edge.

## Structure
- Package alu_pkg: ALUOp localparams above, opcode constants (OP, OP_IMM, BRANCH), kind enum typedef.
- Sub-module alu_op_decoder: purely combinational Instr -> {ALUOp, use_imm, imm, kind, rd}; operand muxing and both stages live in alu_issue_unit.
- Bench instantiates alu (N=32, logN=5) wired to A/B/ALUOp/Result/Flag.

## Test plan
- add x,5,7 (Rs1Val=5, Rs2Val=7, out_ready=1) -> one cycle later out_valid=1, OutResult=12, OutRd=rd, OutTaken=0.
- srai by 4 on 0x8000_0000 -> OutResult=0xF800_0000; srli -> 0x0800_0000; slti -1 vs 1 -> 1; sltiu -1 vs 1 -> 0.
- blt Rs1=-1, Rs2=1 -> OutTaken=1, OutResult=0; bltu same operands -> OutTaken=0; bne 3,3 -> 0; bgeu 0,0 -> 1.
- Back-to-back 8 instructions with out_ready low for cycles 3-5 -> in_ready falls after two accepts, no loss/duplication, output order preserved.
- Opcode 0000011, and branch funct3=010 -> OutIllegal=1, OutResult=0, OutRd=0, handshake completes.
- rst asserted with both stages full -> next cycle out_valid=0, in_ready=1, ALUOp=00000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU and its issue front-end: ALUOp encodings,
// RV32 major opcodes and the decoded instruction-kind enum.
package alu_pkg;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b01000;
    localparam logic [4:0] ALU_SLL  = 5'b00001;
    localparam logic [4:0] ALU_SLT  = 5'b11100;
    localparam logic [4:0] ALU_SLTU = 5'b11110;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_SRA  = 5'b01101;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_AND  = 5'b00111;
    localparam logic [4:0] ALU_EQ   = 5'b11000;
    localparam logic [4:0] ALU_NE   = 5'b11001;
    localparam logic [4:0] ALU_LT   = 5'b11100;
    localparam logic [4:0] ALU_GE   = 5'b11101;
    localparam logic [4:0] ALU_LTU  = 5'b11110;
    localparam logic [4:0] ALU_GEU  = 5'b11111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        KIND_OP  = 2'd0,
        KIND_BR  = 2'd1,
        KIND_ILL = 2'd2
    } kind_e;

    // LT/LTU branches read the taken bit from Result[0]; the rest use Flag.
    function automatic logic taken_from_result(input logic [4:0] op);
        return (op == ALU_LT) || (op == ALU_LTU);
    endfunction

endpackage

// File: rtl/alu.sv
// Shared combinational ALU. Compare ops (ALUOp[4]=1) return the condition
// both as Result[0] and on Flag; other ops report Result==0 on Flag.
module alu
    import alu_pkg::*;
#(
    parameter int N    = 32,
    parameter int logN = 5
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [4:0]   ALUOp,
    output logic [N-1:0] Result,
    output logic         Flag
);

    logic [logN-1:0] shamt;
    logic            cmp_base;
    logic            cond;

    assign shamt = B[logN-1:0];

    // Compare condition: ALUOp[2:1] picks eq/lt/ltu, ALUOp[0] inverts
    always_comb begin
        cmp_base = (A == B);
        case (ALUOp[2:1])
            2'b10:   cmp_base = ($signed(A) < $signed(B));
            2'b11:   cmp_base = (A < B);
            default: cmp_base = (A == B);
        endcase
        cond = cmp_base ^ ALUOp[0];
    end

    // Result and flag selection
    always_comb begin
        Result = '0;
        if (ALUOp[4]) begin
            Result = {{(N-1){1'b0}}, cond};
        end else begin
            case (ALUOp)
                ALU_ADD: Result = A + B;
                ALU_SUB: Result = A - B;
                ALU_SLL: Result = A << shamt;
                ALU_XOR: Result = A ^ B;
                ALU_SRL: Result = A >> shamt;
                ALU_SRA: Result = $unsigned($signed(A) >>> shamt);
                ALU_OR:  Result = A | B;
                ALU_AND: Result = A & B;
                default: Result = '0;
            endcase
        end
        Flag = ALUOp[4] ? cond : (Result == '0);
    end

endmodule

// File: rtl/alu_op_decoder.sv
// Purely combinational RV32 OP / OP-IMM / BRANCH decoder producing the
// ALUOp encoding, immediate selection, instruction kind and destination.
module alu_op_decoder
    import alu_pkg::*;
#(
    parameter int N    = 32,
    parameter int logN = 5
) (
    input  logic [31:0]  Instr,
    output logic [4:0]   alu_op,
    output logic         use_imm,
    output logic [N-1:0] imm,
    output kind_e        kind,
    output logic [4:0]   rd
);

    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    logic [4:0]   base_op;
    logic [N-1:0] imm_sext;
    logic [N-1:0] imm_shamt;
    logic         bad;
    logic         unused_rs1;

    assign opcode     = Instr[6:0];
    assign funct3     = Instr[14:12];
    assign funct7     = Instr[31:25];
    assign imm_sext   = {{(N-12){Instr[31]}}, Instr[31:20]};
    assign imm_shamt  = {{(N-logN){1'b0}}, Instr[20 +: logN]};
    assign unused_rs1 = ^Instr[19:15];

    // funct3 -> ALUOp for the funct7=0 forms shared by OP and OP-IMM
    always_comb begin
        base_op = ALU_ADD;
        case (funct3)
            3'b000: base_op = ALU_ADD;
            3'b001: base_op = ALU_SLL;
            3'b010: base_op = ALU_SLT;
            3'b011: base_op = ALU_SLTU;
            3'b100: base_op = ALU_XOR;
            3'b101: base_op = ALU_SRL;
            3'b110: base_op = ALU_OR;
            default: base_op = ALU_AND;
        endcase
    end

    // Opcode-level decode; any illegal form collapses to a zeroed ADD entry
    always_comb begin
        alu_op  = ALU_ADD;
        use_imm = 1'b0;
        imm     = '0;
        kind    = KIND_ILL;
        rd      = '0;
        bad     = 1'b0;
        case (opcode)
            OPC_OP: begin
                kind = KIND_OP;
                rd   = Instr[11:7];
                if (funct7 == 7'b0000000) begin
                    alu_op = base_op;
                end else if (funct7 == 7'b0100000 &&
                             (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    // SUB/SRA are ADD/SRL with bit 3 set
                    alu_op = base_op | 5'b01000;
                end else begin
                    bad = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                kind    = KIND_OP;
                rd      = Instr[11:7];
                use_imm = 1'b1;
                imm     = imm_sext;
                alu_op  = base_op;
                if (funct3 == 3'b001) begin
                    imm = imm_shamt;
                    bad = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    imm = imm_shamt;
                    if (funct7 == 7'b0100000)
                        alu_op = ALU_SRA;
                    else if (funct7 != 7'b0000000)
                        bad = 1'b1;
                end
            end
            OPC_BRANCH: begin
                kind = KIND_BR;
                case (funct3)
                    3'b000: alu_op = ALU_EQ;
                    3'b001: alu_op = ALU_NE;
                    3'b100: alu_op = ALU_LT;
                    3'b101: alu_op = ALU_GE;
                    3'b110: alu_op = ALU_LTU;
                    3'b111: alu_op = ALU_GEU;
                    default: bad = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            alu_op  = ALU_ADD;
            use_imm = 1'b0;
            imm     = '0;
            kind    = KIND_ILL;
            rd      = '0;
        end
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Two-stage issue front-end for the shared ALU: stage 1 registers decoded
// ALUOp/A/B (driving the ALU directly), stage 2 captures the ALU answer
// into an output register behind a valid/ready handshake.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int N    = 32,
    parameter int logN = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  Instr,
    input  logic [N-1:0] Rs1Val,
    input  logic [N-1:0] Rs2Val,
    output logic [N-1:0] A,
    output logic [N-1:0] B,
    output logic [4:0]   ALUOp,
    input  logic [N-1:0] Result,
    input  logic         Flag,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] OutResult,
    output logic         OutTaken,
    output logic         OutIllegal,
    output logic [4:0]   OutRd
);

    logic [4:0]   dec_op;
    logic         dec_use_imm;
    logic [N-1:0] dec_imm;
    kind_e        dec_kind;
    logic [4:0]   dec_rd;

    logic         s1_valid_q, s1_valid_d;
    logic [4:0]   s1_aluop_q, s1_aluop_d;
    logic [N-1:0] s1_a_q, s1_a_d;
    logic [N-1:0] s1_b_q, s1_b_d;
    kind_e        s1_kind_q, s1_kind_d;
    logic [4:0]   s1_rd_q, s1_rd_d;

    logic         out_valid_q, out_valid_d;
    logic [N-1:0] out_result_q, out_result_d;
    logic         out_taken_q, out_taken_d;
    logic         out_illegal_q, out_illegal_d;
    logic [4:0]   out_rd_q, out_rd_d;

    logic         s2_free;
    logic         s1_adv;
    logic         in_accept;

    alu_op_decoder #(
        .N    (N),
        .logN (logN)
    ) u_dec (
        .Instr   (Instr),
        .alu_op  (dec_op),
        .use_imm (dec_use_imm),
        .imm     (dec_imm),
        .kind    (dec_kind),
        .rd      (dec_rd)
    );

    assign s2_free   = !out_valid_q || out_ready;
    assign s1_adv    = s1_valid_q && s2_free;
    assign in_ready  = !s1_valid_q || s2_free;
    assign in_accept = in_valid && in_ready;

    // Stage 1: load decoded operands on accept, otherwise hold
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_aluop_d = s1_aluop_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_kind_d  = s1_kind_q;
        s1_rd_d    = s1_rd_q;
        if (in_accept) begin
            s1_valid_d = 1'b1;
            s1_aluop_d = dec_op;
            s1_kind_d  = dec_kind;
            s1_rd_d    = dec_rd;
            if (dec_kind == KIND_ILL) begin
                s1_a_d = '0;
                s1_b_d = '0;
            end else begin
                s1_a_d = Rs1Val;
                s1_b_d = dec_use_imm ? dec_imm : Rs2Val;
            end
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // Stage 2: capture ALU answer when stage 1 advances, drop on pop
    always_comb begin
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_taken_d   = out_taken_q;
        out_illegal_d = out_illegal_q;
        out_rd_d      = out_rd_q;
        if (s1_adv) begin
            out_valid_d   = 1'b1;
            out_result_d  = (s1_kind_q == KIND_OP) ? Result : '0;
            out_taken_d   = (s1_kind_q == KIND_BR) &&
                            (taken_from_result(s1_aluop_q) ? Result[0] : Flag);
            out_illegal_d = (s1_kind_q == KIND_ILL);
            out_rd_d      = s1_rd_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset discarding both stages
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_aluop_q    <= ALU_ADD;
            s1_a_q        <= '0;
            s1_b_q        <= '0;
            s1_kind_q     <= KIND_OP;
            s1_rd_q       <= '0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_taken_q   <= 1'b0;
            out_illegal_q <= 1'b0;
            out_rd_q      <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_aluop_q    <= s1_aluop_d;
            s1_a_q        <= s1_a_d;
            s1_b_q        <= s1_b_d;
            s1_kind_q     <= s1_kind_d;
            s1_rd_q       <= s1_rd_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_taken_q   <= out_taken_d;
            out_illegal_q <= out_illegal_d;
            out_rd_q      <= out_rd_d;
        end
    end

    assign A          = s1_a_q;
    assign B          = s1_b_q;
    assign ALUOp      = s1_aluop_q;
    assign out_valid  = out_valid_q;
    assign OutResult  = out_result_q;
    assign OutTaken   = out_taken_q;
    assign OutIllegal = out_illegal_q;
    assign OutRd      = out_rd_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed-vector bench for alu_issue_unit wired to the shared alu.
module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Instr;
    logic [31:0] Rs1Val, Rs2Val;
    logic [31:0] A, B;
    logic [4:0]  ALUOp;
    logic [31:0] Result;
    logic        Flag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] OutResult;
    logic        OutTaken;
    logic        OutIllegal;
    logic [4:0]  OutRd;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    always #5 clk = ~clk;

    alu_issue_unit #(.N(32), .logN(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Instr      (Instr),
        .Rs1Val     (Rs1Val),
        .Rs2Val     (Rs2Val),
        .A          (A),
        .B          (B),
        .ALUOp      (ALUOp),
        .Result     (Result),
        .Flag       (Flag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .OutResult  (OutResult),
        .OutTaken   (OutTaken),
        .OutIllegal (OutIllegal),
        .OutRd      (OutRd)
    );

    alu #(.N(32), .logN(5)) u_alu (
        .A      (A),
        .B      (B),
        .ALUOp  (ALUOp),
        .Result (Result),
        .Flag   (Flag)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {imm, 5'd1, f3, rd, opc};
    endfunction

    // One instruction through an empty pipe with out_ready held high
    task automatic issue_one(input string tag, input logic [31:0] ins,
                             input logic [31:0] r1, input logic [31:0] r2,
                             input logic [4:0] e_op, input logic [31:0] e_a, input logic [31:0] e_b,
                             input logic [31:0] e_res, input logic e_tk, input logic e_ill,
                             input logic [4:0] e_rd);
        @(posedge clk); #1;
        in_valid = 1'b1; Instr = ins; Rs1Val = r1; Rs2Val = r2; out_ready = 1'b1;
        @(negedge clk);
        check_eq({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; Instr = 32'h0; Rs1Val = 32'h0; Rs2Val = 32'h0;
        @(negedge clk);
        check_eq({tag, ".aluop"}, {27'd0, ALUOp}, {27'd0, e_op});
        check_eq({tag, ".a"}, A, e_a);
        check_eq({tag, ".b"}, B, e_b);
        check_eq({tag, ".early_valid"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
        check_eq({tag, ".result"}, OutResult, e_res);
        check_eq({tag, ".taken"}, {31'd0, OutTaken}, {31'd0, e_tk});
        check_eq({tag, ".illegal"}, {31'd0, OutIllegal}, {31'd0, e_ill});
        check_eq({tag, ".rd"}, {27'd0, OutRd}, {27'd0, e_rd});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned sent;
        int unsigned recv;
        int unsigned occ;
        int unsigned cyc;
        logic        acc, pop, hold_prev, saw_stall;
        logic [31:0] held_res;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        Instr = '0; Rs1Val = '0; Rs2Val = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst.in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst.aluop", {27'd0, ALUOp}, 32'd0);
        check_eq("rst.a", A, 32'd0);
        check_eq("rst.b", B, 32'd0);
        check_eq("rst.result", OutResult, 32'd0);
        check_eq("rst.taken", {31'd0, OutTaken}, 32'd0);
        check_eq("rst.illegal", {31'd0, OutIllegal}, 32'd0);
        check_eq("rst.rd", {27'd0, OutRd}, 32'd0);

        // tag, instr, rs1, rs2, aluop, A, B, result, taken, illegal, rd
        issue_one("add",   enc_r(7'h00, 3'b000, 5'd3, 7'b0110011), 32'd5, 32'd7,
                  5'b00000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 5'd3);
        issue_one("sub",   enc_r(7'h20, 3'b000, 5'd10, 7'b0110011), 32'd5, 32'd7,
                  5'b01000, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 5'd10);
        issue_one("sra",   enc_r(7'h20, 3'b101, 5'd12, 7'b0110011), 32'h8000_0000, 32'd1,
                  5'b01101, 32'h8000_0000, 32'd1, 32'hC000_0000, 1'b0, 1'b0, 5'd12);
        issue_one("sll",   enc_r(7'h00, 3'b001, 5'd11, 7'b0110011), 32'd1, 32'd31,
                  5'b00001, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 5'd11);
        issue_one("xor",   enc_r(7'h00, 3'b100, 5'd13, 7'b0110011), 32'h0000_F0F0, 32'h0000_FF00,
                  5'b00100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0, 1'b0, 5'd13);
        issue_one("srai",  enc_i(12'h404, 3'b101, 5'd5, 7'b0010011), 32'h8000_0000, 32'hDEAD_BEEF,
                  5'b01101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0, 5'd5);
        issue_one("srli",  enc_i(12'h004, 3'b101, 5'd6, 7'b0010011), 32'h8000_0000, 32'hDEAD_BEEF,
                  5'b00101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0, 5'd6);
        issue_one("slti",  enc_i(12'h001, 3'b010, 5'd7, 7'b0010011), 32'hFFFF_FFFF, 32'd0,
                  5'b11100, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 5'd7);
        issue_one("sltiu", enc_i(12'h001, 3'b011, 5'd8, 7'b0010011), 32'hFFFF_FFFF, 32'd0,
                  5'b11110, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 5'd8);
        issue_one("addi",  enc_i(12'hFFF, 3'b000, 5'd9, 7'b0010011), 32'd10, 32'd0,
                  5'b00000, 32'd10, 32'hFFFF_FFFF, 32'd9, 1'b0, 1'b0, 5'd9);
        issue_one("blt",   enc_r(7'h00, 3'b100, 5'b10101, 7'b1100011), 32'hFFFF_FFFF, 32'd1,
                  5'b11100, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 5'd0);
        issue_one("bltu",  enc_r(7'h00, 3'b110, 5'b10101, 7'b1100011), 32'hFFFF_FFFF, 32'd1,
                  5'b11110, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 5'd0);
        issue_one("bne",   enc_r(7'h00, 3'b001, 5'b00001, 7'b1100011), 32'd3, 32'd3,
                  5'b11001, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 5'd0);
        issue_one("bgeu",  enc_r(7'h00, 3'b111, 5'b00001, 7'b1100011), 32'd0, 32'd0,
                  5'b11111, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0);
        issue_one("beq",   enc_r(7'h00, 3'b000, 5'b00001, 7'b1100011), 32'd4, 32'd4,
                  5'b11000, 32'd4, 32'd4, 32'd0, 1'b1, 1'b0, 5'd0);
        issue_one("load",  enc_i(12'h010, 3'b010, 5'd4, 7'b0000011), 32'h1234, 32'h5678,
                  5'b00000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0);
        issue_one("br010", enc_r(7'h00, 3'b010, 5'd4, 7'b1100011), 32'h1234, 32'h5678,
                  5'b00000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0);
        issue_one("opbad", enc_r(7'h20, 3'b100, 5'd4, 7'b0110011), 32'h1234, 32'h5678,
                  5'b00000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0);
        issue_one("sllibad", enc_i(12'h023, 3'b001, 5'd4, 7'b0010011), 32'h1234, 32'h5678,
                  5'b00000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0);

        // Eight back-to-back adds with out_ready low for cycles 3..5
        sent = 0; recv = 0; cyc = 0;
        hold_prev = 1'b0; saw_stall = 1'b0; held_res = '0;
        @(posedge clk);
        while (recv < 8 && cyc < 80) begin
            #1;
            out_ready = !(cyc >= 3 && cyc <= 5);
            if (sent < 8) begin
                in_valid = 1'b1;
                Instr    = enc_r(7'h00, 3'b000, 5'(sent + 1), 7'b0110011);
                Rs1Val   = 32'(100 * sent);
                Rs2Val   = 32'd3;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            occ = sent - recv;
            check_eq("b2b.in_ready", {31'd0, in_ready}, {31'd0, (occ < 2) || out_ready});
            if (hold_prev) begin
                check_eq("b2b.hold_valid", {31'd0, out_valid}, 32'd1);
                check_eq("b2b.hold_result", OutResult, held_res);
            end
            hold_prev = out_valid && !out_ready;
            held_res  = OutResult;
            if (!in_ready) saw_stall = 1'b1;
            acc = in_valid && in_ready;
            pop = out_valid && out_ready;
            if (pop) begin
                check_eq("b2b.result", OutResult, 32'(100 * recv + 3));
                check_eq("b2b.rd", {27'd0, OutRd}, 32'(recv + 1));
            end
            @(posedge clk);
            if (acc) sent++;
            if (pop) recv++;
            cyc++;
        end
        #1 in_valid = 1'b0;
        check_eq("b2b.recv", recv, 32'd8);
        check_eq("b2b.sent", sent, 32'd8);
        check_eq("b2b.stalled", {31'd0, saw_stall}, 32'd1);

        // Fill both stages, then reset mid-stream
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1;
        Instr = enc_r(7'h00, 3'b000, 5'd1, 7'b0110011); Rs1Val = 32'd1; Rs2Val = 32'd1;
        @(posedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("full.out_valid", {31'd0, out_valid}, 32'd1);
        check_eq("full.in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst.out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("midrst.in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("midrst.aluop", {27'd0, ALUOp}, 32'd0);
        check_eq("midrst.a", A, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("midrst.drained", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
